imem_loader: RTL

- Sits directly upstream of the IF-stage instruction memory and drives its write port (write enable, write byte-address, write data).
- Receives a program as a byte stream from the debug UART receiver and packs each group of 4 bytes into a 32-bit word, little-endian.
- Writes each word to consecutive word-aligned addresses starting at 0.
- Stops on a HALT word or when memory is full, and reports completion to the debug controller.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader_word_assembler.sv | 38 +++
 rtl/imem_loader.sv | 113 +++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Imported by the loader top and its word assembler.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] IMEM_HALT_WORD = 32'hFFFF_FFFF;
  localparam int          IMEM_BYTES     = 256;
  localparam int          IMEM_WORDS     = IMEM_BYTES / 4;

  // Byte address of a word index (word-aligned, zero-extended).
  function automatic logic [31:0] word_byte_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
// master = the loader itself, slave = the surrounding debug/memory logic.
interface imem_loader_if #(
  parameter int CNT_W = 7
);
  logic             start;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             imem_write_en;
  logic [31:0]      imem_addr_wr;
  logic [31:0]      imem_data;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] word_count;

  modport master (
    input  start, rx_valid, rx_data,
    output imem_write_en, imem_addr_wr, imem_data, busy, done, overflow, word_count
  );

  modport slave (
    output start, rx_valid, rx_data,
    input  imem_write_en, imem_addr_wr, imem_data, busy, done, overflow, word_count
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; word_ready marks the
// cycle in which the 4th byte is accepted, with word already complete.
module imem_loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  rx_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]      byte_cnt_r;
  logic [2:0][7:0] lane_r;

  // Byte counter and the three lower byte lanes; the top lane is rx_data itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_r <= 2'd0;
      lane_r     <= '0;
    end else if (clear) begin
      byte_cnt_r <= 2'd0;
      lane_r     <= '0;
    end else if (accept) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      case (byte_cnt_r)
        2'd0:    lane_r[0] <= rx_data;
        2'd1:    lane_r[1] <= rx_data;
        2'd2:    lane_r[2] <= rx_data;
        default: lane_r    <= lane_r;
      endcase
    end
  end

  assign word       = {rx_data, lane_r[2], lane_r[1], lane_r[0]};
  assign word_ready = accept && (byte_cnt_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a UART byte stream into instruction memory, one
// little-endian word per 4 bytes, stopping on HALT_WORD or a full memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MAX_WORDS = IMEM_WORDS,
  parameter logic [31:0] HALT_WORD = IMEM_HALT_WORD
) (
  input  logic        clk,
  input  logic        reset,
  imem_loader_if.master bus
);

  localparam int CNT_W = $clog2(MAX_WORDS) + 1;

  state_t           state_r;
  state_t           state_s;
  logic             write_en_r;
  logic [31:0]      addr_r;
  logic [31:0]      data_r;
  logic [CNT_W-1:0] word_count_r;
  logic             overflow_r;

  logic             accept_s;
  logic             term_s;
  logic             clear_s;
  logic             word_ready_s;
  logic             write_s;
  logic [31:0]      word_s;

  // start always wins over a byte arriving in the same cycle.
  assign accept_s = (state_r == LOAD) && bus.rx_valid && !bus.start;
  assign term_s   = (state_r == LOAD) && write_en_r && !bus.start &&
                    ((data_r == HALT_WORD) || (word_count_r == CNT_W'(MAX_WORDS)));
  assign clear_s  = bus.start || term_s;
  assign write_s  = word_ready_s && !term_s;

  imem_loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_s),
    .accept     (accept_s),
    .rx_data    (bus.rx_data),
    .word       (word_s),
    .word_ready (word_ready_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = LOAD;
        else           state_s = IDLE;
      end
      LOAD: begin
        if (bus.start)   state_s = LOAD;
        else if (term_s) state_s = DONE;
        else             state_s = LOAD;
      end
      DONE: begin
        if (bus.start) state_s = LOAD;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Write port, word counter and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_en_r   <= 1'b0;
      addr_r       <= 32'd0;
      data_r       <= 32'd0;
      word_count_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      write_en_r <= write_s;
      if (write_s) begin
        data_r       <= word_s;
        addr_r       <= word_byte_addr(30'(word_count_r));
        word_count_r <= word_count_r + CNT_W'(1);
      end else if (bus.start) begin
        // A write already in flight completes this cycle; the address resets after it.
        addr_r       <= 32'd0;
        word_count_r <= '0;
      end
      if (bus.start) begin
        overflow_r <= 1'b0;
      end else if (term_s && (data_r != HALT_WORD)) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.imem_write_en = write_en_r;
  assign bus.imem_addr_wr  = addr_r;
  assign bus.imem_data     = data_r;
  assign bus.word_count    = word_count_r;
  assign bus.overflow      = overflow_r;
  assign bus.busy          = (state_r == LOAD);
  assign bus.done          = (state_r == DONE);

endmodule
